// File: rtl/load_store_unit.sv
// load_store_unit: multi-cycle data-memory access unit.
//   Accepts one load/store request in idle and drives a req/ack memory port with byte enables.
//   It extends the load data and holds the result for write-back. It flags misaligned accesses,
//   illegal width codes and accesses that time out waiting for mem_ack.
// Ports:
//   clk, rst_n         clock, synchronous active-low reset
//   start              request pulse (sampled only in idle)
//   is_store, funct3   access kind and RV32 width code
//   addr, wdata        byte address and store data
//   busy, done, err    status: busy while requesting, one-cycle done, err valid with done
//   load_data          extended load result, held until the next successful load
//   mem_*              data-memory port (word address, byte enables, replicated store data)
module load_store_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] load_data,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  typedef enum logic [1:0] {StIdle, StReq, StDone} state_e;

  // Last counter value before the access is abandoned (counter starts at 0 in the first REQ cycle).
  localparam logic [7:0] TimeoutLast = 8'(TIMEOUT_CYCLES - 1);

  state_e      state_q, state_d;
  logic        is_store_q, is_store_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [1:0]  off_q, off_d;
  logic [31:0] wdata_q, wdata_d;
  logic [29:0] waddr_q, waddr_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        err_q, err_d;
  logic [31:0] load_data_q, load_data_d;

  logic        illegal;
  logic [3:0]  be;
  logic [31:0] store_word;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] load_ext;

  // Decode of the incoming request: bad width code or misaligned address.
  always_comb begin
    illegal = 1'b0;
    unique case (funct3)
      3'b000:         illegal = 1'b0;
      3'b001:         illegal = addr[0];
      3'b010:         illegal = (addr[1:0] != 2'b00);
      3'b100:         illegal = is_store;
      3'b101:         illegal = is_store | addr[0];
      default:        illegal = 1'b1;
    endcase
  end

  // Byte enables and lane-replicated store data from the latched request.
  always_comb begin
    be         = 4'b1111;
    store_word = wdata_q;
    unique case (funct3_q[1:0])
      2'b00: begin
        be         = 4'b0001 << off_q;
        store_word = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        be         = off_q[1] ? 4'b1100 : 4'b0011;
        store_word = {2{wdata_q[15:0]}};
      end
      default: begin
        be         = 4'b1111;
        store_word = wdata_q;
      end
    endcase
  end

  // Lane select and extension of the returned word.
  always_comb begin
    rd_byte = mem_rdata[7:0];
    unique case (off_q)
      2'b00: rd_byte = mem_rdata[7:0];
      2'b01: rd_byte = mem_rdata[15:8];
      2'b10: rd_byte = mem_rdata[23:16];
      default: rd_byte = mem_rdata[31:24];
    endcase
    rd_half  = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    load_ext = mem_rdata;
    unique case (funct3_q)
      3'b000:  load_ext = {{24{rd_byte[7]}}, rd_byte};
      3'b001:  load_ext = {{16{rd_half[15]}}, rd_half};
      3'b100:  load_ext = {24'h0, rd_byte};
      3'b101:  load_ext = {16'h0, rd_half};
      default: load_ext = mem_rdata;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    is_store_d  = is_store_q;
    funct3_d    = funct3_q;
    off_d       = off_q;
    wdata_d     = wdata_q;
    waddr_d     = waddr_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    load_data_d = load_data_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          is_store_d = is_store;
          funct3_d   = funct3;
          off_d      = addr[1:0];
          wdata_d    = wdata;
          waddr_d    = addr[31:2];
          cnt_d      = 8'd0;
          err_d      = illegal;
          state_d    = illegal ? StDone : StReq;
        end
      end
      StReq: begin
        if (mem_ack) begin
          if (!is_store_q) load_data_d = load_ext;
          cnt_d   = 8'd0;
          err_d   = 1'b0;
          state_d = StDone;
        end else if (cnt_q == TimeoutLast) begin
          cnt_d   = 8'd0;
          err_d   = 1'b1;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      is_store_q  <= 1'b0;
      funct3_q    <= 3'b000;
      off_q       <= 2'b00;
      wdata_q     <= 32'h0;
      waddr_q     <= 30'h0;
      cnt_q       <= 8'd0;
      err_q       <= 1'b0;
      load_data_q <= 32'h0;
    end else begin
      state_q     <= state_d;
      is_store_q  <= is_store_d;
      funct3_q    <= funct3_d;
      off_q       <= off_d;
      wdata_q     <= wdata_d;
      waddr_q     <= waddr_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      load_data_q <= load_data_d;
    end
  end

  // Memory port is driven only while requesting so it reads as zero otherwise.
  always_comb begin
    busy      = (state_q == StReq);
    done      = (state_q == StDone);
    err       = done & err_q;
    load_data = load_data_q;
    mem_req   = busy;
    mem_we    = busy & is_store_q;
    mem_addr  = busy ? {waddr_q, 2'b00} : 32'h0;
    mem_be    = busy ? be : 4'b0000;
    mem_wdata = (busy && is_store_q) ? store_word : 32'h0;
  end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        is_store;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        busy, done, err;
  logic [31:0] load_data;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  always #5 clk = ~clk;

  load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .is_store (is_store),
    .funct3   (funct3),
    .addr     (addr),
    .wdata    (wdata),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .load_data(load_data),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_be   (mem_be),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_ack  (mem_ack)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        st;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          d;        // cycle (1 = first REQ cycle) in which ack is raised; 0 = never
    int          sst;      // cycle in which a second start is pulsed; 0 = none
    logic        exp_err;
    int          exp_done;
    int          exp_req;
    logic [3:0]  exp_be;
    logic [31:0] exp_wd;
    logic [31:0] exp_ld;
  } vec_t;

  // Observations from the last access.
  int          done_cyc, req_n, post_bad;
  logic        err_s, we_s, unstable;
  logic [3:0]  be_s;
  logic [31:0] addr_s, wd_s, ld_s;

  task automatic run_access(input logic st, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] wd, input logic [31:0] rd, input int d,
                            input int sst);
    bit first;
    done_cyc = 0; req_n = 0; post_bad = 0; err_s = 0; we_s = 0; unstable = 0;
    be_s = '0; addr_s = '0; wd_s = '0; ld_s = '0; first = 1;
    @(posedge clk); #1;
    start = 1; is_store = st; funct3 = f3; addr = a; wdata = wd; mem_rdata = rd; mem_ack = 0;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      start = 0; mem_ack = 0;
      if (mem_req) begin
        req_n++;
        if (first) begin
          be_s = mem_be; we_s = mem_we; addr_s = mem_addr; wd_s = mem_wdata; first = 0;
        end else if (be_s !== mem_be || we_s !== mem_we || addr_s !== mem_addr ||
                     wd_s !== mem_wdata) begin
          unstable = 1;
        end
      end
      mem_ack = (n == d);
      start   = (n == sst);
      if (done) begin
        done_cyc = n; err_s = err; ld_s = load_data;
        break;
      end
    end
    for (int n = 0; n < 4; n++) begin
      @(posedge clk); #1;
      start = 0; mem_ack = 0;
      if (mem_req || done || busy) post_bad++;
    end
  endtask

  vec_t vecs[14];

  initial begin
    rst_n = 0; start = 0; is_store = 0; funct3 = 0; addr = 0; wdata = 0;
    mem_rdata = 0; mem_ack = 0;
    //               st  f3      addr          wdata         rdata         d  sst err dn rq be       wd            ld
    vecs[0]  = '{1'b0, 3'b010, 32'h0000_0100, 32'h0,        32'hDEAD_BEEF, 3, 4, 1'b0, 4, 3, 4'b1111, 32'h0,        32'hDEAD_BEEF};
    vecs[1]  = '{1'b0, 3'b000, 32'h0000_0203, 32'h0,        32'h8011_2233, 1, 0, 1'b0, 2, 1, 4'b1000, 32'h0,        32'hFFFF_FF80};
    vecs[2]  = '{1'b0, 3'b100, 32'h0000_0203, 32'h0,        32'h8011_2233, 2, 0, 1'b0, 3, 2, 4'b1000, 32'h0,        32'h0000_0080};
    vecs[3]  = '{1'b1, 3'b000, 32'h0000_0102, 32'h0000_00A5, 32'h1111_1111, 1, 0, 1'b0, 2, 1, 4'b0100, 32'hA5A5_A5A5, 32'h0000_0080};
    vecs[4]  = '{1'b1, 3'b001, 32'h0000_0102, 32'h0000_1234, 32'h1111_1111, 2, 0, 1'b0, 3, 2, 4'b1100, 32'h1234_1234, 32'h0000_0080};
    vecs[5]  = '{1'b0, 3'b010, 32'h0000_0101, 32'h0,        32'h2222_2222, 1, 0, 1'b1, 1, 0, 4'b0000, 32'h0,        32'h0000_0080};
    vecs[6]  = '{1'b0, 3'b011, 32'h0000_0100, 32'h0,        32'h2222_2222, 1, 1, 1'b1, 1, 0, 4'b0000, 32'h0,        32'h0000_0080};
    vecs[7]  = '{1'b0, 3'b001, 32'h0000_0102, 32'h0,        32'h8001_0000, 1, 0, 1'b0, 2, 1, 4'b1100, 32'h0,        32'hFFFF_8001};
    vecs[8]  = '{1'b0, 3'b101, 32'h0000_0100, 32'h0,        32'h1234_8001, 1, 0, 1'b0, 2, 1, 4'b0011, 32'h0,        32'h0000_8001};
    vecs[9]  = '{1'b1, 3'b010, 32'h0000_010C, 32'hCAFE_F00D, 32'h0,        1, 0, 1'b0, 2, 1, 4'b1111, 32'hCAFE_F00D, 32'h0000_8001};
    vecs[10] = '{1'b1, 3'b100, 32'h0000_0100, 32'h0000_0077, 32'h0,        1, 0, 1'b1, 1, 0, 4'b0000, 32'h0,        32'h0000_8001};
    vecs[11] = '{1'b0, 3'b010, 32'h0000_0200, 32'h0,        32'h3333_3333, 0, 2, 1'b1, 5, 4, 4'b1111, 32'h0,        32'h0000_8001};
    vecs[12] = '{1'b0, 3'b000, 32'h0000_0201, 32'h0,        32'h0000_7F00, 1, 0, 1'b0, 2, 1, 4'b0010, 32'h0,        32'h0000_007F};
    vecs[13] = '{1'b0, 3'b001, 32'h0000_0101, 32'h0,        32'h4444_4444, 1, 0, 1'b1, 1, 0, 4'b0000, 32'h0,        32'h0000_007F};

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_done", {31'h0, done}, 32'h0);
    chk("rst_err", {31'h0, err}, 32'h0);
    chk("rst_req", {31'h0, mem_req}, 32'h0);
    chk("rst_ld", load_data, 32'h0);
    chk("rst_addr", mem_addr, 32'h0);
    rst_n = 1;

    for (int i = 0; i < 14; i++) begin
      logic [31:0] ea;
      run_access(vecs[i].st, vecs[i].f3, vecs[i].addr, vecs[i].wdata, vecs[i].rdata,
                 vecs[i].d, vecs[i].sst);
      ea = (vecs[i].exp_req > 0) ? {vecs[i].addr[31:2], 2'b00} : 32'h0;
      chk($sformatf("v%0d_done_cycle", i), done_cyc, vecs[i].exp_done);
      chk($sformatf("v%0d_err", i), {31'h0, err_s}, {31'h0, vecs[i].exp_err});
      chk($sformatf("v%0d_req_cycles", i), req_n, vecs[i].exp_req);
      chk($sformatf("v%0d_be", i), {28'h0, be_s}, {28'h0, vecs[i].exp_be});
      chk($sformatf("v%0d_we", i), {31'h0, we_s},
          {31'h0, vecs[i].st && (vecs[i].exp_req > 0)});
      chk($sformatf("v%0d_addr", i), addr_s, ea);
      chk($sformatf("v%0d_wdata", i), wd_s, vecs[i].exp_wd);
      chk($sformatf("v%0d_load_data", i), ld_s, vecs[i].exp_ld);
      chk($sformatf("v%0d_stable", i), {31'h0, unstable}, 32'h0);
      chk($sformatf("v%0d_quiet_after", i), post_bad, 0);
    end

    // mem_ack while idle must not complete anything or touch load_data.
    mem_rdata = 32'h5555_5555; mem_ack = 1;
    begin
      int bad = 0;
      for (int n = 0; n < 3; n++) begin
        @(posedge clk); #1;
        if (done || mem_req) bad++;
      end
      mem_ack = 0;
      chk("idle_ack_quiet", bad, 0);
      chk("idle_ack_ld", load_data, 32'h0000_007F);
    end

    // Reset during REQ: request drops on the next edge, no done for the aborted access.
    @(posedge clk); #1;
    start = 1; is_store = 0; funct3 = 3'b010; addr = 32'h300; mem_ack = 0;
    @(posedge clk); #1;
    start = 0;
    chk("rr_req_before", {31'h0, mem_req}, 32'h1);
    @(posedge clk); #1;
    rst_n = 0;
    @(posedge clk); #1;
    rst_n = 1;
    chk("rr_req", {31'h0, mem_req}, 32'h0);
    chk("rr_busy", {31'h0, busy}, 32'h0);
    chk("rr_done", {31'h0, done}, 32'h0);
    chk("rr_ld", load_data, 32'h0);
    begin
      int bad = 0;
      for (int n = 0; n < 4; n++) begin
        @(posedge clk); #1;
        if (done || mem_req) bad++;
      end
      chk("rr_no_done", bad, 0);
    end
    run_access(1'b0, 3'b001, 32'h0, 32'h0, 32'h0000_FFFE, 1, 0);
    chk("rr_lh_done_cycle", done_cyc, 2);
    chk("rr_lh_err", {31'h0, err_s}, 32'h0);
    chk("rr_lh_be", {28'h0, be_s}, 32'h3);
    chk("rr_lh_ld", ld_s, 32'hFFFF_FFFE);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, got hang expected finish");
    $fatal(1);
  end

endmodule
